hub75_capture: RTL
==================

Name: hub75_capture

Overview:
- Synthesizable sink for the HUB75-style panel stream driven by the LED matrix controller: clk_out, r1/g1/b1, r2/g2/b2, a–d, latch_SR.
- Deserialises each shifted row pair into a 1-bit-per-colour pixel store and exposes it through a registered readback port.
- Used as an on-chip loopback monitor and as the self-checking end of the controller bench.
- Runs on the system clock and oversamples the panel signals.

Parameters:
COLS, 64, pixels per row shifted between latches
ADDR_W, 4, row-select width (a..d); panel height = 2*2^ADDR_W rows

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
hub_clk  in  1  panel shift clock (controller clk_out)
r1  in  1  upper-half red
g1  in  1  upper-half green
b1  in  1  upper-half blue
r2  in  1  lower-half red
g2  in  1  lower-half green
b2  in  1  lower-half blue
row_sel  in  ADDR_W  {d,c,b,a}
latch_SR  in  1  row latch strobe
rd_en  in  1  readback request
rd_row  in  ADDR_W+1  readback row, 0..2*2^ADDR_W-1
rd_col  in  $clog2(COLS)  readback column
rd_data  out  3  {r,g,b} of the addressed pixel
rd_valid  out  1  rd_data valid
frame_done  out  1  one-cycle pulse: every row address committed
err_len  out  1  sticky: latch seen with shift count != COLS
err_clr  in  1  clears err_len

Behaviour:
- Reset (async, n_rst=0): rd_data=0, rd_valid=0, frame_done=0, err_len=0, bit_cnt=0, row_seen=0, shift registers and pixel store all 0. Reset mid-row discards partial data.
- Input sync: hub_clk, latch_SR, all six colour bits and row_sel each pass through the same 2-flop synchroniser, so data stays aligned with its clock edge.
- Edge detect on the synchronised hub_clk and latch_SR, using a third flop.
- Input timing: hub_clk high and low must each last >=2 clk periods. Data must be stable from 1 clk before to 1 clk after the hub_clk rise.
- Shift: on a detected hub_clk rise, shift the six colour bits into six COLS-bit shift registers. The first bit shifted lands at column COLS-1; the last bit lands at column 0.
- bit_cnt increments per rise and saturates at COLS+1. Shifting continues past COLS, and the oldest bits are dropped.
- Latch rise with bit_cnt==COLS:
  - write upper shift data to store row row_sel;
  - write lower shift data to row row_sel+2^ADDR_W;
  - set row_seen[row_sel]; bit_cnt<=0.
- Latch rise with bit_cnt!=COLS: no store write, err_len<=1, bit_cnt<=0.
- Hub_clk rise and latch rise detected in the same clk: latch is processed first, using the pre-shift data; the shift then counts as bit 1 of the next row.
- frame_done: the cycle after row_seen becomes all ones, frame_done pulses for 1 clk and row_seen clears. Repeated latches of the same row do not double-count.
- err_clr: clears err_len. If err_clr and a new error occur in the same cycle, the error wins.
- Readback:
  - rd_en sampled at cycle N; rd_data and rd_valid appear at N+1. rd_valid=0 when rd_en was 0.
  - rd_data holds its last value when not reading.
  - Read of a row being committed in the same cycle returns the old contents.
  - Out-of-range rd_col returns 0 with rd_valid=1.

Optional Feature:
- Macro: HUB_CAP_STATS_EN.
- When defined: adds output latch_cnt[15:0], counting every detected latch rise (good or bad). Reset 0; wraps 0xFFFF->0x0000.
- When undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then read row 5 col 7 -> rd_data=0, rd_valid=1 one cycle after rd_en.
- Shift 64 bits with r1=1 only at the 44th shift, row_sel=0, then latch:
  - row 0 col 20 -> 3'b100, all other row-0 cols 0;
  - row 16 all 0;
  - err_len=0.
- Shift 63 bits, then latch -> err_len=1, store unchanged. Assert err_clr -> err_len=0.
- Commit all 16 row addresses with full rows -> frame_done pulses exactly once, 1 clk wide. Re-latch row 3 alone -> no pulse.
- Assert n_rst mid-row after 30 shifts, then shift a full 64-bit row and latch -> no error, data correct.
- With HUB_CAP_STATS_EN defined, 3 good latches + 1 short latch -> latch_cnt=4. Preload 0xFFFF via 65535 latches, one more -> 0.

Source files
------------

// File: rtl/hub75_capture.sv
// hub75_capture: HUB75 panel stream sink with row-pair pixel store and registered readback; define HUB_CAP_STATS_EN to add the latch_cnt output
module hub75_capture #(
  parameter int COLS = 64,
  parameter int ADDR_W = 4
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      hub_clk,
  input  logic                      r1,
  input  logic                      g1,
  input  logic                      b1,
  input  logic                      r2,
  input  logic                      g2,
  input  logic                      b2,
  input  logic [ADDR_W-1:0]         row_sel,
  input  logic                      latch_SR,
  input  logic                      rd_en,
  input  logic [ADDR_W:0]           rd_row,
  input  logic [$clog2(COLS)-1:0]   rd_col,
  output logic [2:0]                rd_data,
  output logic                      rd_valid,
  output logic                      frame_done,
  output logic                      err_len,
  input  logic                      err_clr
`ifdef HUB_CAP_STATS_EN
  ,
  output logic [15:0]               latch_cnt
`endif
);
  localparam int HALF = 2 ** ADDR_W;
  localparam int ROWS = 2 * HALF;
  localparam int CW = $clog2(COLS + 2);
  localparam int SW = ADDR_W + 8;
  logic [SW-1:0] s1_q, s2_q;
  logic hub3_q, lat3_q;
  logic [COLS-1:0] sr_q [6];
  logic [COLS-1:0] mem_q [ROWS][3];
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [HALF-1:0] seen_q, seen_d;
  logic err_q, err_d, fd_q, fd_d, rd_valid_q;
  logic [2:0] rd_data_q, rd_data_d, pix;
  logic hub_rise, lat_rise, good;
  logic [5:0] col_s;
  logic [ADDR_W-1:0] row_s;
  assign col_s = s2_q[5:0];
  assign row_s = s2_q[SW-1:8];
  assign hub_rise = s2_q[6] & ~hub3_q;
  assign lat_rise = s2_q[7] & ~lat3_q;
  assign good = lat_rise && bit_cnt_q == CW'(COLS);
  assign pix = 32'(rd_col) < COLS ? {mem_q[rd_row][0][rd_col], mem_q[rd_row][1][rd_col], mem_q[rd_row][2][rd_col]} : 3'b000;
  assign rd_data = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign frame_done = fd_q;
  assign err_len = err_q;
  // two-flop synchroniser for every panel input plus a third flop on clock and latch for edge detection
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      s1_q <= '0;
      s2_q <= '0;
      hub3_q <= 1'b0;
      lat3_q <= 1'b0;
    end else begin
      s1_q <= {row_sel, latch_SR, hub_clk, r1, g1, b1, r2, g2, b2};
      s2_q <= s1_q;
      hub3_q <= s2_q[6];
      lat3_q <= s2_q[7];
    end
  // commit pre-shift row data on a good latch, then shift new colour bits in at column 0
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      for (int i = 0; i < 6; i++) sr_q[i] <= '0;
      for (int r = 0; r < ROWS; r++) for (int c = 0; c < 3; c++) mem_q[r][c] <= '0;
    end else begin
      if (good) for (int c = 0; c < 3; c++) begin
        mem_q[{1'b0, row_s}][c] <= sr_q[c];
        mem_q[{1'b1, row_s}][c] <= sr_q[c+3];
      end
      if (hub_rise) for (int i = 0; i < 6; i++) sr_q[i] <= {sr_q[i][COLS-2:0], col_s[5-i]};
    end
  // next-state for shift count, row tracking, error flag and readback; a latch restarts the count and a coincident rise becomes bit 1
  always_comb begin
    bit_cnt_d = lat_rise ? (hub_rise ? CW'(1) : '0) : (hub_rise && bit_cnt_q != CW'(COLS + 1)) ? bit_cnt_q + 1'b1 : bit_cnt_q;
    fd_d = &seen_q;
    seen_d = ((&seen_q) ? '0 : seen_q) | (good ? HALF'(1) << row_s : '0);
    err_d = (lat_rise && !good) ? 1'b1 : err_clr ? 1'b0 : err_q;
    rd_data_d = rd_en ? pix : rd_data_q;
  end
  // control and readback registers
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      bit_cnt_q <= '0;
      seen_q <= '0;
      fd_q <= 1'b0;
      err_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q <= 3'b000;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      seen_q <= seen_d;
      fd_q <= fd_d;
      err_q <= err_d;
      rd_valid_q <= rd_en;
      rd_data_q <= rd_data_d;
    end
`ifdef HUB_CAP_STATS_EN
  logic [15:0] cnt_q;
  assign latch_cnt = cnt_q;
  // count every latch rise, good or bad, wrapping at 16 bits
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) cnt_q <= '0;
    else if (lat_rise) cnt_q <= cnt_q + 16'd1;
`endif
endmodule
